// File: rtl/ldm_writeback_seq.sv
// ============================================================================
// Module   : ldm_writeback_seq
// Purpose  : LDMIA write-back sequencer. It fetches one word per set bit of the
//            register list and writes the words into the register file in
//            ascending order. R15 loads are redirected to the PC path.
// Config   : LDM_BASE_WB_EN enables the BASE state, which writes the updated
//            base register back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldm_writeback_seq (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] RegList,
    input  logic [3:0]  Rn,
    input  logic [31:0] BaseAddr,
    input  logic        W,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemValid,
    input  logic [31:0] MemRData,
    output logic        RegWrite,
    output logic [3:0]  A3,
    output logic [31:0] WD3,
    output logic        PCWrite,
    output logic [31:0] PCData,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MEM   = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
`ifdef LDM_BASE_WB_EN
        ,
        S_BASE  = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_list;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  w_idx;
    logic [15:0] w_list_next;

`ifdef LDM_BASE_WB_EN
    logic [3:0]  r_rn;
    logic        r_base_wb;
`else
    logic        w_unused_cfg;
    assign w_unused_cfg = ^{W, Rn};
`endif

    // Lowest set bit of the remaining list selects the destination register.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_list_next = r_list & (r_list - 16'd1);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_list    <= 16'd0;
            r_addr    <= 32'd0;
            r_data    <= 32'd0;
`ifdef LDM_BASE_WB_EN
            r_rn      <= 4'd0;
            r_base_wb <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_list    <= RegList;
                        r_addr    <= BaseAddr;
`ifdef LDM_BASE_WB_EN
                        r_rn      <= Rn;
                        // A base register that is also loaded keeps the loaded value.
                        r_base_wb <= W && (Rn != 4'hF) && !RegList[Rn];
`endif
                    end
                end
                S_MEM: begin
                    if (MemValid) begin
                        r_data <= MemRData;
                    end
                end
                S_WRITE: begin
                    // After the last word r_addr equals the written-back base value.
                    r_list <= w_list_next;
                    r_addr <= r_addr + 32'd4;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        MemReq       = 1'b0;
        MemAddr      = 32'd0;
        RegWrite     = 1'b0;
        A3           = 4'd0;
        WD3          = 32'd0;
        PCWrite      = 1'b0;
        PCData       = 32'd0;
        Busy         = (r_state != S_IDLE);
        Done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_next = (RegList != 16'd0) ? S_MEM : S_DONE;
                end
            end
            S_MEM: begin
                MemReq  = 1'b1;
                MemAddr = r_addr;
                if (MemValid) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_idx == 4'hF) begin
                    PCWrite = 1'b1;
                    PCData  = {r_data[31:2], 2'b00};
                end else begin
                    RegWrite = 1'b1;
                    A3       = w_idx;
                    WD3      = r_data;
                end
                if (w_list_next != 16'd0) begin
                    w_state_next = S_MEM;
                end else begin
`ifdef LDM_BASE_WB_EN
                    w_state_next = r_base_wb ? S_BASE : S_DONE;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef LDM_BASE_WB_EN
            S_BASE: begin
                RegWrite     = 1'b1;
                A3           = r_rn;
                WD3          = r_addr;
                w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                Done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ldm_writeback_seq.sv
// ============================================================================
// Module   : tb_ldm_writeback_seq
// Purpose  : Cycle-accurate vector bench for ldm_writeback_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldm_writeback_seq;

    localparam int K_IDLE = 0;
    localparam int K_MEM  = 1;
    localparam int K_RW   = 2;
    localparam int K_PC   = 3;
    localparam int K_DONE = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] RegList;
    logic [3:0]  Rn;
    logic [31:0] BaseAddr;
    logic        W;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemValid;
    logic [31:0] MemRData;
    logic        RegWrite;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        PCWrite;
    logic [31:0] PCData;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldm_writeback_seq dut (
        .clk      (clk),
        .Reset    (Reset),
        .Start    (Start),
        .RegList  (RegList),
        .Rn       (Rn),
        .BaseAddr (BaseAddr),
        .W        (W),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemValid (MemValid),
        .MemRData (MemRData),
        .RegWrite (RegWrite),
        .A3       (A3),
        .WD3      (WD3),
        .PCWrite  (PCWrite),
        .PCData   (PCData),
        .Busy     (Busy),
        .Done     (Done)
    );

    // One record per clock cycle: inputs applied in that cycle and the
    // outputs expected in the same cycle (outputs are Moore).
    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] list;
        logic [3:0]  rn;
        logic        w;
        logic [31:0] base;
        logic        mv;
        logic [31:0] rdata;
        int          kind;
        logic [3:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic start, input logic [15:0] list,
                                input logic [3:0] rn, input logic w, input logic [31:0] base,
                                input logic mv, input logic [31:0] rdata, input int kind,
                                input logic [3:0] ea, input logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.start = start; v.list = list; v.rn = rn; v.w = w; v.base = base;
        v.mv = mv; v.rdata = rdata; v.kind = kind; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        logic        e_mr, e_rw, e_pw, e_busy, e_done;
        logic [31:0] e_ma, e_wd, e_pd;
        logic [3:0]  e_a3;
        @(negedge clk);
        Reset = v.rst; Start = v.start; RegList = v.list; Rn = v.rn; W = v.w;
        BaseAddr = v.base; MemValid = v.mv; MemRData = v.rdata;
        #1;
        e_mr   = (v.kind == K_MEM);
        e_ma   = e_mr ? v.ed : 32'd0;
        e_rw   = (v.kind == K_RW);
        e_a3   = e_rw ? v.ea : 4'd0;
        e_wd   = e_rw ? v.ed : 32'd0;
        e_pw   = (v.kind == K_PC);
        e_pd   = e_pw ? v.ed : 32'd0;
        e_busy = (v.kind != K_IDLE);
        e_done = (v.kind == K_DONE);
        checks++;
        if (MemReq !== e_mr || MemAddr !== e_ma || RegWrite !== e_rw || A3 !== e_a3 ||
            WD3 !== e_wd || PCWrite !== e_pw || PCData !== e_pd || Busy !== e_busy ||
            Done !== e_done) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%h rw=%b a3=%0d wd3=%h pcw=%b pcd=%h busy=%b done=%b; want req=%b addr=%h rw=%b a3=%0d wd3=%h pcw=%b pcd=%h busy=%b done=%b",
                     name, MemReq, MemAddr, RegWrite, A3, WD3, PCWrite, PCData, Busy, Done,
                     e_mr, e_ma, e_rw, e_a3, e_wd, e_pw, e_pd, e_busy, e_done);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; RegList = '0; Rn = '0; W = 1'b0;
        BaseAddr = '0; MemValid = 1'b0; MemRData = '0;
        repeat (2) @(posedge clk);

        // Reset held with Start asserted: nothing starts.
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 32'h10, 1, 32'h1, K_IDLE, 0, 0));
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 32'h10, 1, 32'h1, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0, 0, 0, 0, 1, 0, K_IDLE, 0, 0));
        // Two registers, zero wait; Start during DONE is ignored.
        tbl.push_back(mk(0, 1, 16'h0006, 0, 0, 32'h100, 0, 0, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA, K_MEM, 0, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 1, 32'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hB, K_MEM, 0, 32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 2, 32'hB));
        tbl.push_back(mk(0, 1, 16'h0001, 0, 0, 32'h900, 1, 0, K_DONE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, K_IDLE, 0, 0));
        // R0 then R15 redirected to the PC path.
        tbl.push_back(mk(0, 1, 16'h8001, 0, 0, 32'h300, 0, 0, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h11, K_MEM, 0, 32'h300));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 0, 32'h11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2003, K_MEM, 0, 32'h304));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_PC, 0, 32'h2000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_DONE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_IDLE, 0, 0));
        // Base write-back request, Rn=4 not in list.
        tbl.push_back(mk(0, 1, 16'h0003, 4, 1, 32'h200, 0, 0, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA0, K_MEM, 0, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 0, 32'hA0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA1, K_MEM, 0, 32'h204));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 1, 32'hA1));
`ifdef LDM_BASE_WB_EN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 4, 32'h208));
`endif
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_DONE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_IDLE, 0, 0));
        // Rn in the list: loaded value stands, no base write.
        tbl.push_back(mk(0, 1, 16'h0010, 4, 1, 32'h400, 0, 0, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h55, K_MEM, 0, 32'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 4, 32'h55));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_DONE, 0, 0));
        // Address wrap at the top of the address space.
        tbl.push_back(mk(0, 1, 16'h0003, 0, 0, 32'hFFFF_FFFC, 0, 0, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1, K_MEM, 0, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 0, 32'h1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2, K_MEM, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 1, 32'h2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, K_DONE, 0, 0));
        // Empty list: DONE on the next cycle.
        tbl.push_back(mk(0, 1, 16'h0000, 0, 1, 32'h500, 1, 0, K_IDLE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, K_DONE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, K_IDLE, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Memory wait states with a Start pulse that must be ignored.
        step(mk(0, 1, 16'h0001, 0, 0, 32'h600, 0, 0, K_IDLE, 0, 0), "wait_start");
        for (int i = 0; i < 5; i++) begin
            step(mk(0, (i == 2), 16'h00F0, 0, 0, 32'hBAD0, 0, 32'hDEAD, K_MEM, 0, 32'h600),
                 $sformatf("wait%0d", i));
        end
        step(mk(0, 0, 0, 0, 0, 0, 1, 32'h77, K_MEM, 0, 32'h600), "wait_valid");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 0, 32'h77), "wait_write");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, K_DONE, 0, 0), "wait_done");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, K_IDLE, 0, 0), "wait_idle");

        // Reset in MEM of a three-register list aborts without further writes.
        step(mk(0, 1, 16'h0007, 0, 0, 32'h700, 0, 0, K_IDLE, 0, 0), "abort_start");
        step(mk(0, 0, 0, 0, 0, 0, 1, 32'h1, K_MEM, 0, 32'h700), "abort_mem0");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, K_RW, 0, 32'h1), "abort_wr0");
        step(mk(1, 0, 0, 0, 0, 0, 1, 32'h2, K_MEM, 0, 32'h704), "abort_mem1");
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 32'h3, K_IDLE, 0, 0), $sformatf("abort_idle%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
